ctu_clsp_cken_stagger: RTL and testbench



---
 rtl/ctu_clsp_pkg.sv | 14 +
 rtl/ctu_clsp_cken_stagger_if.sv | 31 +++
 rtl/ctu_clsp_retime_pipe.sv | 29 ++
 rtl/ctu_clsp_cken_stagger.sv | 115 +++++++++++
 tb/tb_ctu_clsp_cken_stagger.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ctu_clsp_pkg.sv
// CTU clock-split shared types and defaults.
// Used by the cken stagger retimer and its interface.
package ctu_clsp_pkg;

  typedef enum logic {
    IDLE,
    GAP_WAIT
  } cken_stg_e;

  localparam int CTU_CKEN_NUM_CH = 6;
  localparam int CTU_CKEN_DEPTH  = 2;
  localparam int CTU_CKEN_GAP    = 4;

endpackage

// File: rtl/ctu_clsp_cken_stagger_if.sv
// Request/enable bundle between the CTU and the stagger retimer.
// The master drives requests; the slave returns enables and busy.
interface ctu_clsp_cken_stagger_if
  import ctu_clsp_pkg::*;
#(
  parameter int NUM_CH = CTU_CKEN_NUM_CH
) ();

  logic [NUM_CH-1:0] cken_dl;
  logic              sync_edge;
  logic              force_off;
  logic [NUM_CH-1:0] cken_dg;
  logic              busy;

  modport master (
    output cken_dl,
    output sync_edge,
    output force_off,
    input  cken_dg,
    input  busy
  );

  modport slave (
    input  cken_dl,
    input  sync_edge,
    input  force_off,
    output cken_dg,
    output busy
  );

endinterface

// File: rtl/ctu_clsp_retime_pipe.sv
// WIDTH x DEPTH flop pipeline, synchronous active-high reset.
// Shared by the CTU retime paths.
module ctu_clsp_retime_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stg_q;

  // Shift one stage per clock; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q <= '0;
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign q_o = stg_q[DEPTH-1];

endmodule

// File: rtl/ctu_clsp_cken_stagger.sv
// DRAM clock-enable retimer: turn-offs on the sync edge,
// turn-ons staggered one channel at a time at least GAP apart.
module ctu_clsp_cken_stagger
  import ctu_clsp_pkg::*;
#(
  parameter int NUM_CH = CTU_CKEN_NUM_CH,
  parameter int DEPTH  = CTU_CKEN_DEPTH,
  parameter int GAP    = CTU_CKEN_GAP
) (
  input  logic                    cmp_gclk,
  input  logic                    cmp_grst,
  ctu_clsp_cken_stagger_if.slave  bus
);

  localparam int CW = $clog2(GAP + 1);

  function automatic logic [NUM_CH-1:0] lowest(
    input logic [NUM_CH-1:0] v
  );
    logic [NUM_CH-1:0] r;
    logic              f;
    r = '0;
    f = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i] && !f) begin
        r[i] = 1'b1;
        f    = 1'b1;
      end
    end
    return r;
  endfunction

  logic [NUM_CH-1:0] tgt;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] off;
  logic [NUM_CH-1:0] dg_q, dg_d;
  logic [CW-1:0]     gcnt_q, gcnt_d;
  cken_stg_e         state_q, state_d;
  logic              busy_q, busy_d;

  ctu_clsp_retime_pipe #(
    .WIDTH (NUM_CH),
    .DEPTH (DEPTH)
  ) u_pipe (
    .clk (cmp_gclk),
    .rst (cmp_grst),
    .d_i (bus.cken_dl),
    .q_o (tgt)
  );

  assign pend = tgt & ~dg_q;
  assign off  = ~tgt & dg_q;

  // Next enables and stagger FSM; force_off overrides all.
  // Loading GAP-1 and leaving on reaching zero lets the next
  // turn-on happen exactly GAP cycles after the previous one.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    dg_d    = dg_q;
    if (bus.force_off) begin
      dg_d    = '0;
      state_d = IDLE;
      gcnt_d  = '0;
    end else begin
      if (bus.sync_edge) begin
        dg_d = dg_q & ~off;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.sync_edge && |pend) begin
            dg_d = dg_d | lowest(pend);
            if (GAP > 1) begin
              state_d = GAP_WAIT;
              gcnt_d  = CW'(GAP - 1);
            end
          end
        end
        GAP_WAIT: begin
          if (gcnt_q <= CW'(1)) begin
            state_d = IDLE;
            gcnt_d  = '0;
          end else begin
            gcnt_d = gcnt_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Busy reflects pending work or a running gap, one cycle late.
  always_comb begin
    busy_d = (|pend) | (state_q == GAP_WAIT);
  end

  // State, counter, enable and busy registers.
  always_ff @(posedge cmp_gclk) begin
    if (cmp_grst) begin
      state_q <= IDLE;
      gcnt_q  <= '0;
      dg_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      dg_q    <= dg_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.cken_dg = dg_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_ctu_clsp_cken_stagger.sv
// Bench for ctu_clsp_cken_stagger: two configurations
// against a cycle-level behavioural model.
module tb_ctu_clsp_cken_stagger;

  localparam int NEVER = 1000;

  typedef struct packed {
    logic [5:0]      dg;
    logic [3:0][5:0] pipe;
    int              since;
    logic            busy;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] dl;
  logic       sa, sb, fo;
  logic       chk_on = 1'b0;
  int         total = 0;
  int         bad = 0;
  mdl_t       ma, mb;

  always #5 clk = ~clk;

  ctu_clsp_cken_stagger_if #(.NUM_CH(6)) ifa ();
  ctu_clsp_cken_stagger_if #(.NUM_CH(6)) ifb ();

  assign ifa.cken_dl   = dl;
  assign ifa.sync_edge = sa;
  assign ifa.force_off = fo;
  assign ifb.cken_dl   = dl;
  assign ifb.sync_edge = sb;
  assign ifb.force_off = fo;

  ctu_clsp_cken_stagger #(
    .NUM_CH (6), .DEPTH (2), .GAP (4)
  ) dut_a (
    .cmp_gclk (clk),
    .cmp_grst (rst),
    .bus      (ifa.slave)
  );

  ctu_clsp_cken_stagger #(
    .NUM_CH (6), .DEPTH (3), .GAP (1)
  ) dut_b (
    .cmp_gclk (clk),
    .cmp_grst (rst),
    .bus      (ifb.slave)
  );

  // since = cycles since the last turn-on decision.
  function automatic mdl_t step(
    input mdl_t m, input int depth, input int gap,
    input logic r, input logic [5:0] d,
    input logic sy, input logic f
  );
    mdl_t       n;
    logic [5:0] tgt, pend;
    n = m;
    if (r) begin
      n.dg    = '0;
      n.pipe  = '0;
      n.since = NEVER;
      n.busy  = 1'b0;
      return n;
    end
    tgt    = m.pipe[depth-1];
    pend   = tgt & ~m.dg;
    n.busy = (pend != 0) || (m.since >= 1 && m.since < gap);
    n.pipe[0] = d;
    for (int i = 1; i < 4; i++) n.pipe[i] = m.pipe[i-1];
    n.since = (m.since >= NEVER) ? NEVER : m.since + 1;
    if (f) begin
      n.dg    = '0;
      n.since = NEVER;
    end else if (sy) begin
      n.dg = m.dg & tgt;
      if (pend != 0 && m.since >= gap) begin
        for (int i = 0; i < 6; i++) begin
          if (pend[i]) begin
            n.dg[i] = 1'b1;
            break;
          end
        end
        n.since = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma = step(ma, 2, 4, rst, dl, sa, fo);
    mb = step(mb, 3, 1, rst, dl, sb, fo);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%0h exp=%0h",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_dg", 32'(ifa.cken_dg), 32'(ma.dg));
      chk("a_busy", 32'(ifa.busy), 32'(ma.busy));
      chk("b_dg", 32'(ifb.cken_dg), 32'(mb.dg));
      chk("b_busy", 32'(ifb.busy), 32'(mb.busy));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  int         ons[$];
  logic [5:0] vals[$];
  logic [5:0] prev;

  initial begin
    rst = 1'b1;
    dl  = '0;
    sa  = 1'b0;
    sb  = 1'b0;
    fo  = 1'b0;
    repeat (3) cyc();
    chk_on = 1'b1;
    chk("rst_a_dg", 32'(ifa.cken_dg), 0);
    chk("rst_a_busy", 32'(ifa.busy), 0);
    chk("rst_b_dg", 32'(ifb.cken_dg), 0);

    // DEPTH=3, GAP=1, sync tied high
    rst = 1'b0;
    dl  = 6'b001010;
    sb  = 1'b1;
    repeat (3) cyc();
    chk("b_c3", 32'(ifb.cken_dg), 0);
    cyc();
    chk("b_c4", 32'(ifb.cken_dg), 32'(6'b000010));
    chk("m_b_c4", 32'(mb.dg), 32'(6'b000010));
    cyc();
    chk("b_c5", 32'(ifb.cken_dg), 32'(6'b001010));
    chk("m_b_c5", 32'(mb.dg), 32'(6'b001010));

    // all-on stagger, sync every 2 cycles
    dl = 6'b111111;
    repeat (3) cyc();
    prev = ifa.cken_dg;
    for (int n = 0; n < 40; n++) begin
      sa = (n % 2 == 0);
      cyc();
      if (ifa.cken_dg != prev) begin
        ons.push_back(n);
        vals.push_back(ifa.cken_dg);
      end
      prev = ifa.cken_dg;
    end
    sa = 1'b0;
    chk("p1_count", 32'(ons.size()), 6);
    for (int k = 0; k < ons.size(); k++) begin
      chk("p1_order", 32'(vals[k]), (32'd1 << (k + 1)) - 1);
      if (k > 0) chk("p1_gap", 32'(ons[k] - ons[k-1]), 4);
    end
    chk("p1_busy", 32'(ifa.busy), 0);

    // group turn-off, no stagger
    dl = 6'b000101;
    repeat (3) cyc();
    sa = 1'b1;
    cyc();
    sa = 1'b0;
    chk("p2_off", 32'(ifa.cken_dg), 32'(6'b000101));

    // turn-on bit 3 with turn-off bit 1 on one edge
    dl = 6'b000111;
    repeat (3) cyc();
    sa = 1'b1;
    cyc();
    sa = 1'b0;
    chk("p3_on1", 32'(ifa.cken_dg), 32'(6'b000111));
    repeat (6) cyc();
    dl = 6'b001101;
    repeat (3) cyc();
    sa = 1'b1;
    cyc();
    sa = 1'b0;
    chk("p3_mix", 32'(ifa.cken_dg), 32'(6'b001101));

    // force_off in the middle of a gap
    repeat (6) cyc();
    dl = 6'b111111;
    repeat (3) cyc();
    sa = 1'b1;
    cyc();
    sa = 1'b0;
    chk("p4_on", 32'(ifa.cken_dg), 32'(6'b001111));
    cyc();
    fo = 1'b1;
    cyc();
    chk("p4_force", 32'(ifa.cken_dg), 0);
    fo = 1'b0;
    sa = 1'b1;
    cyc();
    sa = 1'b0;
    chk("p4_restart", 32'(ifa.cken_dg), 32'(6'b000001));

    // reset mid-stagger, then pipeline flush
    repeat (5) cyc();
    sa = 1'b1;
    cyc();
    sa = 1'b0;
    chk("p5_pre_dg", 32'(ifa.cken_dg), 32'(6'b000011));
    chk("p5_pre_busy", 32'(ifa.busy), 1);
    rst = 1'b1;
    cyc();
    chk("p5_rst_dg", 32'(ifa.cken_dg), 0);
    chk("p5_rst_busy", 32'(ifa.busy), 0);
    chk("p5_rst_b", 32'(ifb.cken_dg), 0);
    rst = 1'b0;
    sa  = 1'b1;
    cyc();
    chk("p5_flush1", 32'(ifa.cken_dg), 0);
    cyc();
    chk("p5_flush2", 32'(ifa.cken_dg), 0);
    cyc();
    chk("p5_first", 32'(ifa.cken_dg), 32'(6'b000001));
    sa = 1'b0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) dl = 6'($urandom);
      sa  = ($urandom_range(0, 2) == 0);
      sb  = ($urandom_range(0, 3) != 0);
      fo  = ($urandom_range(0, 60) == 0);
      rst = ($urandom_range(0, 200) == 0);
      cyc();
    end
    rst = 1'b0;
    fo  = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
